alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width, legal range 8..64.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 clk_oe  input  1  clock qualifier; when 0, all state is held.
REQ-005 start  input  1  request pulse; sampled only when clk_oe=1.
REQ-006 cmd  input  4  operation code: `CMD_MOV/ADD/SUB/MUL/DIV/SHR/SHL/XOR/AND/OR from cmd_codes.v.
REQ-007 src0, src1  input  DATA_WIDTH each  operands, captured at accept.
REQ-008 busy  output  1  high from accept until the cycle done is asserted.
REQ-009 done  output  1  one-qualified-cycle completion pulse.
REQ-010 dst, dst_h  output  DATA_WIDTH each  result low word, result high word/remainder.
REQ-011 flags  output  3  {div_zero, carry, zero}.

Function
REQ-012 FSM states IDLE, EXEC, ITER, DONE; a state advances only on edges where clk_oe=1.
REQ-013 Accept is start=1 in IDLE; operands and cmd are latched; start is ignored in every other state.
REQ-014 MOV/ADD/SUB/SHR/SHL/XOR/AND/OR: IDLE->EXEC->DONE; done is asserted 2 qualified edges after the accept edge.
REQ-015 MOV: dst=src0, dst_h=src1.
REQ-016 ADD: {dst_h,dst}=src0+src1, zero-extended to 2*DATA_WIDTH; carry=dst_h[0].
REQ-017 SUB: {dst_h,dst}=src0-src1 in 2*DATA_WIDTH two's complement; carry=1 on borrow.
REQ-018 SHR/SHL: logical shift of src0 by src1; src1>=DATA_WIDTH yields dst=0; dst_h=0.
REQ-019 XOR/AND/OR: bitwise on dst; dst_h=0.
REQ-020 MUL (iterative): unsigned shift-add over DATA_WIDTH ITER cycles, one multiplier bit per cycle; {dst_h,dst}=full product; done is asserted DATA_WIDTH+2 qualified edges after accept.
REQ-021 DIV (iterative): unsigned restoring division, one quotient bit per ITER cycle; dst=quotient, dst_h=remainder; latency DATA_WIDTH+2.
REQ-022 DIV with src1=0: skip ITER; dst=all ones, dst_h=src0, div_zero=1; latency 2.
REQ-023 zero=1 iff dst==0, updated with the result; flags not defined for an op read as 0.
REQ-024 DONE: done=1 for one qualified cycle, then IDLE; done stays high while clk_oe=0 in DONE.
REQ-025 dst, dst_h and flags are updated only at the transition into DONE and hold until the next result.
REQ-026 Undefined cmd: completes as MOV with dst=0, dst_h=0 in 2 edges; never hangs.
REQ-027 start on the same edge that DONE exits to IDLE is not accepted; the earliest re-accept is the following qualified edge.

Reset
REQ-028 rst_n=0 immediately forces IDLE; busy=0, done=0, dst=0, dst_h=0, flags=0, and clears internal iteration counters, regardless of clk or clk_oe.
REQ-029 Reset mid-ITER aborts the operation with no done pulse; the first accept after release behaves as from power-up.

Configuration
REQ-030 Macro ALU_ITER_FAST_MUL_EN defined: MUL uses a single-cycle combinational product via the EXEC path, latency 2, with a result identical to REQ-020.
REQ-031 Macro ALU_ITER_FAST_MUL_EN undefined: MUL is iterative per REQ-020, and no DATA_WIDTH x DATA_WIDTH multiplier is inferred.

Verification
REQ-032 ADD src0=0xFFFFFFFF, src1=1 -> after 2 edges done=1, dst=0, dst_h=1, flags=3'b011.
REQ-033 MUL src0=0x10000, src1=0x10000, macro off -> done at edge 34, dst=0, dst_h=1, busy high edges 1..33; macro on -> same result at edge 2.
REQ-034 DIV src0=100, src1=7 -> dst=14, dst_h=2 at edge 34; DIV src1=0, src0=5 -> edge 2, dst=0xFFFFFFFF, dst_h=5, div_zero=1.
REQ-035 SHL src0=1, src1=40 -> dst=0, zero=1; start pulsed during a DIV -> ignored, DIV result unchanged.
REQ-036 clk_oe toggling 1/0 during MUL -> result correct, with latency counted in qualified edges only; rst_n low at ITER step 10 -> outputs 0 immediately, no done.

Source files
------------

// File: rtl/alu_iter.sv
// Iterative ALU: single-pass ops via EXEC, shift-add MUL and restoring DIV one bit per ITER cycle.
// Latency: 2 qualified edges counting the accept edge; iterative MUL/DIV take DATA_WIDTH+2.
// Backpressure: start is ignored while busy; clk_oe=0 freezes all state. ALU_ITER_FAST_MUL_EN selects single-cycle MUL.
module alu_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_oe,
    input  logic                  start,
    input  logic [3:0]            cmd,
    input  logic [DATA_WIDTH-1:0] src0,
    input  logic [DATA_WIDTH-1:0] src1,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dst,
    output logic [DATA_WIDTH-1:0] dst_h,
    output logic [2:0]            flags
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [3:0] CMD_MOV = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_MUL = 4'd3;
    localparam logic [3:0] CMD_DIV = 4'd4;
    localparam logic [3:0] CMD_SHR = 4'd5;
    localparam logic [3:0] CMD_SHL = 4'd6;
    localparam logic [3:0] CMD_XOR = 4'd7;
    localparam logic [3:0] CMD_AND = 4'd8;
    localparam logic [3:0] CMD_OR  = 4'd9;

    localparam logic [W-1:0]  W_LIM = W'(DATA_WIDTH);
    localparam logic [CW-1:0] LAST  = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

    state_t        state;
    logic [3:0]    cmd_q;
    logic [W-1:0]  op_a, op_b;
    logic [W-1:0]  acc_hi, acc_lo;
    logic [CW-1:0] cnt;

    logic [W-1:0] ex_lo, ex_hi;
    logic         ex_cy, ex_dz, ex_iter;
    logic [W:0]   add_sum, sub_diff;

    assign add_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign sub_diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        ex_lo   = '0;
        ex_hi   = '0;
        ex_cy   = 1'b0;
        ex_dz   = 1'b0;
        ex_iter = 1'b0;
        case (cmd_q)
            CMD_MOV: begin ex_lo = op_a; ex_hi = op_b; end
            CMD_ADD: begin
                ex_lo = add_sum[W-1:0];
                ex_hi = {{(W-1){1'b0}}, add_sum[W]};
                ex_cy = add_sum[W];
            end
            CMD_SUB: begin
                // Borrow out sign-extends the 2W-bit difference into the high word
                ex_lo = sub_diff[W-1:0];
                ex_hi = {W{sub_diff[W]}};
                ex_cy = sub_diff[W];
            end
`ifdef ALU_ITER_FAST_MUL_EN
            CMD_MUL: {ex_hi, ex_lo} = (2*W)'(op_a) * (2*W)'(op_b);
`else
            CMD_MUL: ex_iter = 1'b1;
`endif
            CMD_DIV: begin
                if (op_b == '0) begin
                    ex_lo = '1;
                    ex_hi = op_a;
                    ex_dz = 1'b1;
                end else begin
                    ex_iter = 1'b1;
                end
            end
            CMD_SHR: ex_lo = (op_b >= W_LIM) ? '0 : (op_a >> op_b);
            CMD_SHL: ex_lo = (op_b >= W_LIM) ? '0 : (op_a << op_b);
            CMD_XOR: ex_lo = op_a ^ op_b;
            CMD_AND: ex_lo = op_a & op_b;
            CMD_OR:  ex_lo = op_a | op_b;
            default: ;
        endcase
    end

    // MUL: acc_lo holds the remaining multiplier bits, acc_hi the running partial product.
    // DIV: acc_lo shifts dividend bits out and quotient bits in, acc_hi is the remainder.
    logic [W:0]   mul_sum, rem_sh, div_diff;
    logic [W-1:0] it_hi, it_lo;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : '0);
    assign rem_sh   = {acc_hi, acc_lo[W-1]};
    assign div_diff = rem_sh - {1'b0, op_b};

    always_comb begin
        it_hi = '0;
        it_lo = '0;
        if (cmd_q == CMD_MUL) begin
            it_hi = mul_sum[W:1];
            it_lo = {mul_sum[0], acc_lo[W-1:1]};
        end else if (!div_diff[W]) begin
            it_hi = div_diff[W-1:0];
            it_lo = {acc_lo[W-2:0], 1'b1};
        end else begin
            it_hi = rem_sh[W-1:0];
            it_lo = {acc_lo[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cmd_q  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dst    <= '0;
            dst_h  <= '0;
            flags  <= '0;
        end else if (clk_oe) begin
            case (state)
                IDLE: if (start) begin
                    cmd_q  <= cmd;
                    op_a   <= src0;
                    op_b   <= src1;
                    acc_hi <= '0;
                    acc_lo <= (cmd == CMD_DIV) ? src0 : src1;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= EXEC;
                end
                EXEC: begin
                    if (ex_iter) begin
                        state <= ITER;
                    end else begin
                        dst   <= ex_lo;
                        dst_h <= ex_hi;
                        flags <= {ex_dz, ex_cy, ex_lo == '0};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                ITER: begin
                    acc_hi <= it_hi;
                    acc_lo <= it_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        dst   <= it_lo;
                        dst_h <= it_hi;
                        flags <= {2'b00, it_lo == '0};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Directed and randomized checks of alu_iter against an arithmetic reference model.
module tb_alu_iter;
    localparam int W = 32;

    localparam logic [3:0] C_MOV = 4'd0;
    localparam logic [3:0] C_ADD = 4'd1;
    localparam logic [3:0] C_SUB = 4'd2;
    localparam logic [3:0] C_MUL = 4'd3;
    localparam logic [3:0] C_DIV = 4'd4;
    localparam logic [3:0] C_SHR = 4'd5;
    localparam logic [3:0] C_SHL = 4'd6;
    localparam logic [3:0] C_XOR = 4'd7;
    localparam logic [3:0] C_AND = 4'd8;
    localparam logic [3:0] C_OR  = 4'd9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clk_oe = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   cmd = '0;
    logic [W-1:0] src0 = '0;
    logic [W-1:0] src1 = '0;
    logic         busy, done;
    logic [W-1:0] dst, dst_h;
    logic [2:0]   flags;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_iter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .clk_oe(clk_oe), .start(start), .cmd(cmd),
        .src0(src0), .src1(src1), .busy(busy), .done(done),
        .dst(dst), .dst_h(dst_h), .flags(flags)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result as a 2W-bit value {hi,lo}, flags {div_zero, carry, zero}, latency in edges incl. accept.
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic [2:0] fl, output int lat);
        logic [2*W-1:0] w;
        logic cy, dz;
        w = '0; cy = 1'b0; dz = 1'b0; lat = 2;
        case (c)
            C_MOV: w = {b, a};
            C_ADD: begin w = {32'd0, a} + {32'd0, b}; cy = w[W]; end
            C_SUB: begin w = {32'd0, a} - {32'd0, b}; cy = (a < b); end
            C_MUL: begin
                w = {32'd0, a} * {32'd0, b};
`ifndef ALU_ITER_FAST_MUL_EN
                lat = W + 2;
`endif
            end
            C_DIV: begin
                if (b == 0) begin w = {a, 32'hFFFF_FFFF}; dz = 1'b1; end
                else begin w = {a % b, a / b}; lat = W + 2; end
            end
            C_SHR: w = (b >= W) ? 64'd0 : {32'd0, a >> b};
            C_SHL: w = (b >= W) ? 64'd0 : {32'd0, a << b};
            C_XOR: w = {32'd0, a ^ b};
            C_AND: w = {32'd0, a & b};
            C_OR:  w = {32'd0, a | b};
            default: w = '0;
        endcase
        lo = w[W-1:0];
        hi = w[2*W-1:W];
        fl = {dz, cy, lo == 0};
    endfunction

    task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit toggle_oe, input bit poke_start);
        logic [W-1:0] elo, ehi;
        logic [2:0] efl;
        int lat, q;
        bit busy_ok, got;
        model(c, a, b, elo, ehi, efl, lat);
        @(negedge clk);
        start = 1'b1; cmd = c; src0 = a; src1 = b; clk_oe = 1'b1;
        @(negedge clk);
        start = 1'b0; cmd = 4'($urandom); src0 = $urandom; src1 = $urandom;
        q = 1; busy_ok = 1'b1; got = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done === 1'b1) begin got = 1'b1; break; end
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (poke_start && cyc == 5);
            clk_oe = toggle_oe ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (clk_oe) q++;
        end
        start = 1'b0;
        chk({tag, " done"}, got, 1);
        chk({tag, " latency"}, q, lat);
        chk({tag, " busy_during"}, busy_ok, 1);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " dst"}, dst, elo);
        chk({tag, " dst_h"}, dst_h, ehi);
        chk({tag, " flags"}, flags, efl);
        clk_oe = 1'b0;
        @(negedge clk);
        chk({tag, " done_hold"}, done, 1);
        clk_oe = 1'b1;
        @(negedge clk);
        chk({tag, " done_clear"}, {busy, done}, 2'b00);
        chk({tag, " dst_keep"}, {dst_h, dst}, {ehi, elo});
    endtask

    initial begin
        bit quiet;
        logic [3:0] rc;
        logic [W-1:0] ra, rb;

        #1 rst_n = 1'b0;
        #2;
        chk("reset_outputs", {busy, done, dst, dst_h, flags}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("add_carry", C_ADD, 32'hFFFF_FFFF, 32'd1, 0, 0);
        chk("add_carry_flags_const", flags, 3'b011);
        run_op("mul_16x16", C_MUL, 32'h0001_0000, 32'h0001_0000, 0, 0);
        run_op("div_100_7", C_DIV, 32'd100, 32'd7, 0, 0);
        chk("div_100_7_const", {dst_h, dst}, {32'd2, 32'd14});
        run_op("div_zero", C_DIV, 32'd5, 32'd0, 0, 0);
        run_op("shl_40", C_SHL, 32'd1, 32'd40, 0, 0);
        run_op("div_poke", C_DIV, 32'hDEAD_BEEF, 32'd1234, 0, 1);
        run_op("mul_oe", C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        run_op("sub_borrow", C_SUB, 32'd3, 32'd5, 0, 0);
        run_op("shr_31", C_SHR, 32'h8000_0000, 32'd31, 0, 0);
        run_op("undef_cmd", 4'hF, 32'h1234, 32'h5678, 0, 0);

        // start held across the DONE->IDLE edge is only taken on the next qualified edge
        @(negedge clk);
        start = 1'b1; cmd = C_ADD; src0 = 32'd3; src1 = 32'd4; clk_oe = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("reaccept_done", done, 1);
        start = 1'b1; cmd = C_MOV; src0 = 32'h55; src1 = 32'h66;
        @(negedge clk);
        chk("reaccept_ignored", {busy, done}, 2'b00);
        @(negedge clk);
        chk("reaccept_taken", busy, 1);
        start = 1'b0;
        @(negedge clk);
        chk("reaccept_result", {done, dst_h, dst}, {1'b1, 32'h66, 32'h55});
        @(negedge clk);

        // Reset during the tenth ITER step of a DIV
        @(negedge clk);
        start = 1'b1; cmd = C_DIV; src0 = 32'hFFFF_0000; src1 = 32'd3; clk_oe = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("iter_busy", {busy, done}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset", {busy, done, dst, dst_h, flags}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("no_done_after_abort", quiet, 1);
        run_op("after_reset_div", C_DIV, 32'd1000, 32'd33, 0, 0);

        for (int i = 0; i < 20; i++) begin
            rc = 4'($urandom_range(0, 11));
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op($sformatf("rand%0d_cmd%0d", i, rc), rc, ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
